// File: rtl/reservation_station_multi.sv
// Multi-entry reservation station for one execution unit.
// Operands are captured at dispatch or forwarded from the broadcast channels.
// The oldest ready entry is issued through a valid/ready handshake.
// Age order is held in a pairwise matrix: older_q[i][j]=1 means slot i is older than slot j.
module reservation_station_multi #(
    parameter int ENTRIES   = 4,
    parameter int ROBsize   = 16,
    parameter int DATA_W    = 64,
    parameter int NUM_SRC   = 3,
    parameter int NUM_BCAST = 3,
    parameter int CMD_W     = 10,
    // Derived widths; leave at their defaults.
    parameter int TAG_W     = $clog2(ROBsize + 1),
    parameter int OCC_W     = $clog2(ENTRIES + 1)
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          flush_i,
    input  logic                          disp_valid_i,
    output logic                          disp_ready_o,
    input  logic [NUM_SRC*TAG_W-1:0]      disp_src_tag_i,
    input  logic [NUM_SRC*(DATA_W+1)-1:0] disp_src_val_i,
    input  logic [CMD_W-1:0]              disp_cmd_i,
    input  logic [TAG_W-1:0]              disp_dest_tag_i,
    input  logic [NUM_BCAST-1:0]          bcast_valid_i,
    input  logic [NUM_BCAST*TAG_W-1:0]    bcast_tag_i,
    input  logic [NUM_BCAST*DATA_W-1:0]   bcast_val_i,
    output logic                          issue_valid_o,
    input  logic                          issue_ready_i,
    output logic [NUM_SRC*DATA_W-1:0]     issue_src_val_o,
    output logic [CMD_W-1:0]              issue_cmd_o,
    output logic [TAG_W-1:0]              issue_dest_tag_o,
    output logic [OCC_W-1:0]              occupancy_o
);

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [DATA_W-1:0] data_t;

    // Registered entry state
    logic [ENTRIES-1:0]                busy_q, busy_d;
    tag_t  [ENTRIES-1:0][NUM_SRC-1:0]  tag_q, tag_d;
    data_t [ENTRIES-1:0][NUM_SRC-1:0]  val_q, val_d;
    logic  [ENTRIES-1:0][CMD_W-1:0]    cmd_q, cmd_d;
    tag_t  [ENTRIES-1:0]               dest_q, dest_d;
    logic  [ENTRIES-1:0][ENTRIES-1:0]  older_q, older_d;

    // Unpacked broadcast and dispatch fields
    tag_t  [NUM_BCAST-1:0] bc_tag;
    data_t [NUM_BCAST-1:0] bc_val;
    logic  [NUM_BCAST-1:0] bc_ok;
    tag_t  [NUM_SRC-1:0]   disp_raw_tag;
    data_t [NUM_SRC-1:0]   disp_raw_val;
    logic  [NUM_SRC-1:0]   disp_raw_vld;

    // Post-wakeup view and control
    tag_t  [ENTRIES-1:0][NUM_SRC-1:0] wk_tag;
    data_t [ENTRIES-1:0][NUM_SRC-1:0] wk_val;
    tag_t  [NUM_SRC-1:0]              dc_tag;
    data_t [NUM_SRC-1:0]              dc_val;
    logic  [ENTRIES-1:0]              ready;
    logic  [ENTRIES-1:0]              sel;
    logic  [ENTRIES-1:0]              free_oh;
    logic                             disp_fire;
    logic                             issue_fire;

    // Split the flat input buses; a channel with tag 0 is never a valid producer
    always_comb begin
        for (int c = 0; c < NUM_BCAST; c++) begin
            bc_tag[c] = bcast_tag_i[c*TAG_W +: TAG_W];
            bc_val[c] = bcast_val_i[c*DATA_W +: DATA_W];
            bc_ok[c]  = bcast_valid_i[c] & (bc_tag[c] != '0);
        end
        for (int s = 0; s < NUM_SRC; s++) begin
            disp_raw_tag[s] = disp_src_tag_i[s*TAG_W +: TAG_W];
            disp_raw_val[s] = disp_src_val_i[s*(DATA_W+1) +: DATA_W];
            disp_raw_vld[s] = disp_src_val_i[s*(DATA_W+1) + DATA_W];
        end
    end

    // Wakeup every pending source; descending loop so channel 0 wins ties
    always_comb begin
        for (int e = 0; e < ENTRIES; e++) begin
            ready[e] = busy_q[e];
            for (int s = 0; s < NUM_SRC; s++) begin
                wk_tag[e][s] = tag_q[e][s];
                wk_val[e][s] = val_q[e][s];
                for (int c = NUM_BCAST - 1; c >= 0; c--) begin
                    if (bc_ok[c] && (bc_tag[c] == tag_q[e][s])) begin
                        wk_tag[e][s] = '0;
                        wk_val[e][s] = bc_val[c];
                    end
                end
                ready[e] = ready[e] & (wk_tag[e][s] == '0);
            end
        end
    end

    // Capture dispatched sources: supplied value, else same-cycle forward, else keep tag
    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            dc_tag[s] = disp_raw_tag[s];
            dc_val[s] = disp_raw_val[s];
            if (disp_raw_vld[s]) begin
                dc_tag[s] = '0;
            end else begin
                for (int c = NUM_BCAST - 1; c >= 0; c--) begin
                    if (bc_ok[c] && (bc_tag[c] == disp_raw_tag[s])) begin
                        dc_tag[s] = '0;
                        dc_val[s] = bc_val[c];
                    end
                end
            end
        end
    end

    // Lowest-index free slot, one-hot
    always_comb begin
        logic found;
        found   = 1'b0;
        free_oh = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            if (!busy_q[e] && !found) begin
                free_oh[e] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // Oldest ready entry; the first-found guard keeps sel one-hot
    always_comb begin
        logic found;
        logic cand;
        found = 1'b0;
        sel   = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            cand = ready[e];
            for (int j = 0; j < ENTRIES; j++) begin
                if (j != e && ready[j] && older_q[j][e]) cand = 1'b0;
            end
            if (cand && !found) begin
                sel[e] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    // Issue mux; all fields read zero when nothing is presented
    always_comb begin
        issue_valid_o    = |sel;
        issue_src_val_o  = '0;
        issue_cmd_o      = '0;
        issue_dest_tag_o = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            if (sel[e]) begin
                for (int s = 0; s < NUM_SRC; s++)
                    issue_src_val_o[s*DATA_W +: DATA_W] = wk_val[e][s];
                issue_cmd_o      = cmd_q[e];
                issue_dest_tag_o = dest_q[e];
            end
        end
    end

    // Occupancy and dispatch acceptance come from registered busy bits only
    always_comb begin
        occupancy_o = '0;
        for (int e = 0; e < ENTRIES; e++)
            occupancy_o = occupancy_o + OCC_W'(busy_q[e]);
        disp_ready_o = ~&busy_q;
        disp_fire    = disp_valid_i & disp_ready_o & ~flush_i;
        issue_fire   = issue_valid_o & issue_ready_i;
    end

    // Next state: wakeup always, issue frees, dispatch fills, flush clears
    always_comb begin
        older_d = older_q;
        for (int e = 0; e < ENTRIES; e++) begin
            busy_d[e] = busy_q[e] & ~(issue_fire & sel[e]);
            tag_d[e]  = wk_tag[e];
            val_d[e]  = wk_val[e];
            cmd_d[e]  = cmd_q[e];
            dest_d[e] = dest_q[e];
            if (disp_fire && free_oh[e]) begin
                busy_d[e] = 1'b1;
                tag_d[e]  = dc_tag;
                val_d[e]  = dc_val;
                cmd_d[e]  = disp_cmd_i;
                dest_d[e] = disp_dest_tag_i;
                // New entry is younger than everything currently busy
                for (int j = 0; j < ENTRIES; j++) begin
                    older_d[e][j] = 1'b0;
                    older_d[j][e] = busy_q[j];
                end
            end
        end
        if (flush_i) begin
            busy_d  = '0;
            older_d = '0;
        end
    end

    // State registers, async active-low reset
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            busy_q  <= '0;
            tag_q   <= '0;
            val_q   <= '0;
            cmd_q   <= '0;
            dest_q  <= '0;
            older_q <= '0;
        end else begin
            busy_q  <= busy_d;
            tag_q   <= tag_d;
            val_q   <= val_d;
            cmd_q   <= cmd_d;
            dest_q  <= dest_d;
            older_q <= older_d;
        end
    end

endmodule

// File: tb/tb_reservation_station_multi.sv
// Bench for reservation_station_multi: directed vector table, hand-written
// corner sequences, then random traffic against an age-ordered queue model.
module tb_reservation_station_multi;
    localparam int NE = 4;
    localparam int TW = 5;
    localparam int DW = 64;
    localparam int NS = 3;
    localparam int NB = 3;
    localparam int CW = 10;
    localparam int OW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush, dv, dr, iv, ir;
    logic [NS*TW-1:0]      d_tag;
    logic [NS*(DW+1)-1:0]  d_val;
    logic [CW-1:0]         d_cmd;
    logic [TW-1:0]         d_dest;
    logic [NB-1:0]         b_v;
    logic [NB*TW-1:0]      b_tag;
    logic [NB*DW-1:0]      b_val;
    logic [NS*DW-1:0]      i_val;
    logic [CW-1:0]         i_cmd;
    logic [TW-1:0]         i_dest;
    logic [OW-1:0]         occ;

    int n_chk = 0;
    int n_fail = 0;

    reservation_station_multi dut (
        .clk_i(clk), .reset_ni(rst_n), .flush_i(flush),
        .disp_valid_i(dv), .disp_ready_o(dr),
        .disp_src_tag_i(d_tag), .disp_src_val_i(d_val),
        .disp_cmd_i(d_cmd), .disp_dest_tag_i(d_dest),
        .bcast_valid_i(b_v), .bcast_tag_i(b_tag), .bcast_val_i(b_val),
        .issue_valid_o(iv), .issue_ready_i(ir),
        .issue_src_val_o(i_val), .issue_cmd_o(i_cmd),
        .issue_dest_tag_o(i_dest), .occupancy_o(occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr_in();
        dv = 0; flush = 0; ir = 0;
        d_tag = '0; d_val = '0; d_cmd = '0; d_dest = '0;
        b_v = '0; b_tag = '0; b_val = '0;
    endtask

    // src0 pending on ptag when ptag!=0; sources carry base, base+1, base+2
    task automatic disp_set(input logic [TW-1:0] dest, input logic [TW-1:0] ptag, input logic [DW-1:0] base);
        dv = 1; d_dest = dest; d_cmd = CW'(dest);
        for (int s = 0; s < NS; s++) begin
            d_val[s*(DW+1) +: DW+1] = {(s != 0 || ptag == '0), base + DW'(s)};
            d_tag[s*TW +: TW] = (s == 0) ? ptag : '0;
        end
    endtask

    task automatic bc_set(input int c, input logic [TW-1:0] t, input logic [DW-1:0] v);
        b_v[c] = 1'b1;
        b_tag[c*TW +: TW] = t;
        b_val[c*DW +: DW] = v;
    endtask

    task automatic adv();
        @(posedge clk); #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic dv; logic [TW-1:0] st0; logic [15:0] v0; logic [TW-1:0] dest;
        logic [2:0] bv; logic [2:0][TW-1:0] bt; logic [2:0][15:0] bx;
        logic ir; logic fl;
        logic e_iv; logic [TW-1:0] e_dest; logic [15:0] e_v0; logic [OW-1:0] e_occ; logic e_dr;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t row(input logic dv_, input logic [TW-1:0] st0, input logic [15:0] v0,
                                 input logic [TW-1:0] dest, input logic [2:0] bv, input logic [14:0] bt,
                                 input logic [47:0] bx, input logic ir_, input logic fl,
                                 input logic e_iv, input logic [TW-1:0] e_dest, input logic [15:0] e_v0,
                                 input logic [OW-1:0] e_occ, input logic e_dr);
        vec_t r;
        r.dv = dv_; r.st0 = st0; r.v0 = v0; r.dest = dest; r.bv = bv; r.bt = bt; r.bx = bx;
        r.ir = ir_; r.fl = fl; r.e_iv = e_iv; r.e_dest = e_dest; r.e_v0 = e_v0;
        r.e_occ = e_occ; r.e_dr = e_dr;
        return r;
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [NS-1:0][TW-1:0] tag;
        logic [NS-1:0][DW-1:0] val;
        logic [CW-1:0]         cmd;
        logic [TW-1:0]         dest;
    } ment_t;
    ment_t mq[$];  // oldest at index 0

    function automatic void bc_find(input logic [TW-1:0] t, output logic hit, output logic [DW-1:0] v);
        hit = 0; v = '0;
        for (int c = 0; c < NB; c++)
            if (!hit && b_v[c] && t != '0 && b_tag[c*TW +: TW] == t) begin
                hit = 1; v = b_val[c*DW +: DW];
            end
    endfunction

    task automatic rnd_inputs();
        clr_in();
        dv = 1'($urandom_range(0, 1));
        d_cmd = CW'($urandom);
        d_dest = TW'($urandom_range(1, 16));
        for (int s = 0; s < NS; s++) begin
            d_val[s*(DW+1) +: DW+1] = {1'($urandom_range(0, 1)), $urandom, $urandom};
            d_tag[s*TW +: TW] = TW'($urandom_range(1, 4));
        end
        for (int c = 0; c < NB; c++)
            if ($urandom_range(0, 2) == 0) bc_set(c, TW'($urandom_range(0, 4)), {$urandom, $urandom});
        ir = ($urandom_range(0, 3) != 0);
        flush = ($urandom_range(0, 39) == 0);
    endtask

    task automatic model_step();
        ment_t w[$];
        ment_t e, n;
        int pick;
        logic hit, all0;
        logic [DW-1:0] v;
        logic [TW-1:0] raw;
        @(negedge clk);
        w = mq;
        for (int i = 0; i < w.size(); i++) begin
            e = w[i];
            for (int s = 0; s < NS; s++)
                if (e.tag[s] != '0) begin
                    bc_find(e.tag[s], hit, v);
                    if (hit) begin e.tag[s] = '0; e.val[s] = v; end
                end
            w[i] = e;
        end
        pick = -1;
        for (int i = 0; i < w.size(); i++) begin
            all0 = 1;
            for (int s = 0; s < NS; s++) if (w[i].tag[s] != '0) all0 = 0;
            if (all0 && pick < 0) pick = i;
        end
        chk("rnd_issue_valid", 64'(iv), 64'(pick >= 0));
        chk("rnd_disp_ready", 64'(dr), 64'(mq.size() < NE));
        chk("rnd_occupancy", 64'(occ), 64'(mq.size()));
        if (pick >= 0) begin
            chk("rnd_dest", 64'(i_dest), 64'(w[pick].dest));
            chk("rnd_cmd", 64'(i_cmd), 64'(w[pick].cmd));
            for (int s = 0; s < NS; s++) chk("rnd_src", i_val[s*DW +: DW], w[pick].val[s]);
        end
        if (flush) begin
            w.delete();
        end else begin
            if (pick >= 0 && ir) w.delete(pick);
            if (dv && mq.size() < NE) begin
                n.cmd = d_cmd; n.dest = d_dest;
                for (int s = 0; s < NS; s++) begin
                    raw = d_tag[s*TW +: TW];
                    if (d_val[s*(DW+1) + DW]) begin
                        n.tag[s] = '0; n.val[s] = d_val[s*(DW+1) +: DW];
                    end else begin
                        bc_find(raw, hit, v);
                        n.tag[s] = hit ? '0 : raw;
                        n.val[s] = hit ? v : '0;
                    end
                end
                w.push_back(n);
            end
        end
        mq = w;
        adv();
    endtask

    initial begin
        clr_in();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        adv();

        //             dv st0  v0      dst bv      bt                    bx                              ir fl  iv dst  v0      occ dr
        tbl.push_back(row(0, 0, 16'h0,  0, 3'b000, 15'h0,                48'h0,                          0, 0,  0, 0,  16'h0,  0, 1));
        tbl.push_back(row(1, 0, 16'hA,  3, 3'b000, 15'h0,                48'h0,                          0, 0,  0, 0,  16'h0,  0, 1));
        tbl.push_back(row(0, 0, 16'h0,  0, 3'b000, 15'h0,                48'h0,                          0, 0,  1, 3,  16'hA,  1, 1));
        tbl.push_back(row(0, 0, 16'h0,  0, 3'b000, 15'h0,                48'h0,                          1, 0,  1, 3,  16'hA,  1, 1));
        tbl.push_back(row(0, 0, 16'h0,  0, 3'b000, 15'h0,                48'h0,                          0, 0,  0, 0,  16'h0,  0, 1));
        tbl.push_back(row(1, 5, 16'h50, 6, 3'b000, 15'h0,                48'h0,                          0, 0,  0, 0,  16'h0,  0, 1));
        tbl.push_back(row(0, 0, 16'h0,  0, 3'b000, 15'h0,                48'h0,                          1, 0,  0, 0,  16'h0,  1, 1));
        tbl.push_back(row(0, 0, 16'h0,  0, 3'b100, {5'd5, 5'd0, 5'd0},   {16'hD0, 16'h0, 16'h0},         0, 0,  1, 6,  16'hD0, 1, 1));
        tbl.push_back(row(0, 0, 16'h0,  0, 3'b000, 15'h0,                48'h0,                          1, 0,  1, 6,  16'hD0, 1, 1));
        tbl.push_back(row(0, 0, 16'h0,  0, 3'b000, 15'h0,                48'h0,                          0, 0,  0, 0,  16'h0,  0, 1));
        tbl.push_back(row(1, 7, 16'h70, 8, 3'b000, 15'h0,                48'h0,                          0, 0,  0, 0,  16'h0,  0, 1));
        tbl.push_back(row(0, 0, 16'h0,  0, 3'b001, 15'h0,                {16'h0, 16'h0, 16'h99},         1, 0,  0, 0,  16'h0,  1, 1));
        tbl.push_back(row(0, 0, 16'h0,  0, 3'b011, {5'd0, 5'd7, 5'd7},   {16'h0, 16'h22, 16'h11},        0, 0,  1, 8,  16'h11, 1, 1));
        tbl.push_back(row(0, 0, 16'h0,  0, 3'b000, 15'h0,                48'h0,                          1, 0,  1, 8,  16'h11, 1, 1));
        tbl.push_back(row(0, 0, 16'h0,  0, 3'b000, 15'h0,                48'h0,                          0, 0,  0, 0,  16'h0,  0, 1));
        tbl.push_back(row(1, 9, 16'h90, 10, 3'b110, {5'd9, 5'd9, 5'd0},  {16'h44, 16'h33, 16'h0},        0, 0,  0, 0,  16'h0,  0, 1));
        tbl.push_back(row(0, 0, 16'h0,  0, 3'b000, 15'h0,                48'h0,                          1, 0,  1, 10, 16'h33, 1, 1));
        tbl.push_back(row(0, 0, 16'h0,  0, 3'b000, 15'h0,                48'h0,                          0, 0,  0, 0,  16'h0,  0, 1));

        foreach (tbl[i]) begin
            clr_in();
            ir = tbl[i].ir; flush = tbl[i].fl;
            if (tbl[i].dv) disp_set(tbl[i].dest, tbl[i].st0, 64'(tbl[i].v0));
            for (int c = 0; c < NB; c++)
                if (tbl[i].bv[c]) bc_set(c, tbl[i].bt[c], 64'(tbl[i].bx[c]));
            @(negedge clk);
            chk($sformatf("vec%0d_issue_valid", i), 64'(iv), 64'(tbl[i].e_iv));
            chk($sformatf("vec%0d_dest", i), 64'(i_dest), 64'(tbl[i].e_dest));
            chk($sformatf("vec%0d_src0", i), i_val[DW-1:0], 64'(tbl[i].e_v0));
            chk($sformatf("vec%0d_occupancy", i), 64'(occ), 64'(tbl[i].e_occ));
            chk($sformatf("vec%0d_disp_ready", i), 64'(dr), 64'(tbl[i].e_dr));
            adv();
        end

        // Fill all slots while stalled, try a fifth, then drain in age order
        for (int k = 1; k <= NE; k++) begin
            clr_in(); disp_set(TW'(k), '0, 64'(k * 16)); adv();
        end
        clr_in(); disp_set(TW'(5), '0, 64'h500);
        @(negedge clk);
        chk("fill_disp_ready", 64'(dr), 64'd0);
        chk("fill_occupancy", 64'(occ), 64'd4);
        adv();
        clr_in(); ir = 1;
        for (int k = 1; k <= NE; k++) begin
            @(negedge clk);
            chk("fill_issue_valid", 64'(iv), 64'd1);
            chk("fill_order", 64'(i_dest), 64'(k));
            chk("fill_occ_drain", 64'(occ), 64'(5 - k));
            adv();
        end
        @(negedge clk);
        chk("fill_empty_valid", 64'(iv), 64'd0);
        chk("fill_empty_occ", 64'(occ), 64'd0);
        adv();

        // Younger ready entry bypasses an older one waiting on tag 9
        clr_in(); disp_set(TW'(11), TW'(9), 64'h110); adv();
        clr_in(); disp_set(TW'(12), '0, 64'h120); adv();
        clr_in(); ir = 1;
        @(negedge clk);
        chk("ooo_first", 64'(i_dest), 64'd12);
        adv();
        @(negedge clk);
        chk("ooo_wait_valid", 64'(iv), 64'd0);
        chk("ooo_wait_occ", 64'(occ), 64'd1);
        adv();
        bc_set(0, TW'(9), 64'h77);
        @(negedge clk);
        chk("ooo_second", 64'(i_dest), 64'd11);
        chk("ooo_second_src0", i_val[DW-1:0], 64'h77);
        adv();
        clr_in();
        @(negedge clk);
        chk("ooo_empty_occ", 64'(occ), 64'd0);
        adv();

        // Flush with three busy entries and a concurrent dispatch
        for (int k = 0; k < 3; k++) begin
            clr_in(); disp_set(TW'(20 + k), TW'(15), 64'h200); adv();
        end
        clr_in(); flush = 1; ir = 1; disp_set(TW'(13), '0, 64'h130);
        @(negedge clk);
        chk("flush_pre_occ", 64'(occ), 64'd3);
        adv();
        clr_in(); ir = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("flush_occ", 64'(occ), 64'd0);
            chk("flush_no_issue", 64'(iv), 64'd0);
            adv();
        end

        // Asynchronous reset mid-stream
        for (int k = 1; k <= 2; k++) begin
            clr_in(); disp_set(TW'(k), '0, 64'h300); adv();
        end
        clr_in();
        @(negedge clk);
        chk("prerst_valid", 64'(iv), 64'd1);
        adv();
        #2 rst_n = 0;
        #1;
        chk("arst_valid", 64'(iv), 64'd0);
        chk("arst_occ", 64'(occ), 64'd0);
        chk("arst_ready", 64'(dr), 64'd1);
        chk("arst_dest", 64'(i_dest), 64'd0);
        chk("arst_cmd", 64'(i_cmd), 64'd0);
        chk("arst_src", 64'(|i_val), 64'd0);
        @(negedge clk);
        rst_n = 1;
        adv();
        @(negedge clk);
        chk("postrst_occ", 64'(occ), 64'd0);
        adv();

        // Random traffic against the queue model
        mq.delete();
        for (int n = 0; n < 2000; n++) begin
            rnd_inputs();
            model_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/reservation_station_multi.md
# reservation_station_multi

Multi-entry, parametrised reservation station for one execution unit. It generalises the single-entry forwarding station to ENTRIES slots, NUM_SRC source operands per entry and NUM_BCAST result-forwarding channels. Entries issue oldest-ready-first through a valid/ready handshake. It sits between decode/ROB dispatch and the execution unit.

## Interface
Parameters:
- ENTRIES, 4, number of station slots (2..16).
- ROBsize, 16, ROB depth; TAG_W = $clog2(ROBsize+1); tag 0 means "no pending producer".
- DATA_W, 64, operand width.
- NUM_SRC, 3, source operands per instruction.
- NUM_BCAST, 3, forwarding channels; a lower index has higher priority (0=exec, 1=mem, 2=commit).
- CMD_W, 10, command field width.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous clear of all entries (ROB restore).
- disp_valid_i  in  1  dispatch request.
- disp_ready_o  out  1  at least one slot is free.
- disp_src_tag_i  in  NUM_SRC*TAG_W  producer tag per source.
- disp_src_val_i  in  NUM_SRC*(DATA_W+1)  per source; MSB is the value-valid bit, low DATA_W bits are the value.
- disp_cmd_i  in  CMD_W  command.
- disp_dest_tag_i  in  TAG_W  destination ROB tag.
- bcast_valid_i  in  NUM_BCAST  channel valid; each bit is also gated by tag!=0.
- bcast_tag_i  in  NUM_BCAST*TAG_W  result tag per channel.
- bcast_val_i  in  NUM_BCAST*DATA_W  result value per channel.
- issue_valid_o  out  1  a ready entry is presented.
- issue_ready_i  in  1  execution unit accepts (replaces stall).
- issue_src_val_o  out  NUM_SRC*DATA_W  operands, forwarding applied.
- issue_cmd_o  out  CMD_W  command.
- issue_dest_tag_o  out  TAG_W  destination tag.
- occupancy_o  out  $clog2(ENTRIES+1)  count of busy entries.

## Operation
- Per-entry state: busy, NUM_SRC × {tag, value}, cmd, dest tag, plus an ENTRIES×ENTRIES age matrix (older[i][j]).
- Dispatch is accepted when disp_valid_i & disp_ready_o & ~flush_i. The request is written into the lowest-index free slot. The new entry is marked younger than every busy entry.
- Dispatch source capture, per source:
  - If the valid bit is 1: store tag=0 and the supplied value.
  - Otherwise, if any broadcast channel matches the tag this cycle: store tag=0 and the value from the highest-priority matching channel.
  - Otherwise: store the tag and leave the value don't-care.
- Wakeup: for each busy entry and each source with tag!=0, a match on any channel clears the tag and loads the value from the highest-priority matching channel. This happens every cycle, whether or not the entry issues.
- An entry is ready when it is busy and every source tag is zero after this cycle's wakeup. Readiness is combinational, so forwarding and issue can happen in the same cycle.
- Select: the oldest ready entry drives the issue outputs. Its operand values are the post-wakeup values.
- The issue handshake fires when issue_valid_o & issue_ready_i. The selected entry clears busy at the next edge. If issue_ready_i is 0, nothing leaves and wakeup still updates the entries.
- flush_i clears every busy bit and the age matrix at the next edge. Flush overrides any dispatch or issue in that cycle; that dispatch is dropped.
- occupancy_o = popcount(busy).

## Timing
- Reset (reset_ni=0, async): all busy=0 and the age matrix is cleared. Outputs go to issue_valid_o=0, disp_ready_o=1, occupancy_o=0. issue_src_val_o, cmd and dest tag are all 0 (they are gated to 0 whenever issue_valid_o=0).
- Dispatch-to-issue minimum latency is 1 cycle: an entry written at edge N can issue in cycle N+1. There is no same-cycle dispatch→issue bypass.
- A broadcast in cycle C for the last pending source makes issue_valid_o=1 in cycle C, carrying the broadcast value.
- disp_ready_o is computed from the registered busy bits only. A slot freed by an issue in the same cycle becomes usable the next cycle. When full, disp_ready_o=0 and dispatch is ignored.
- Simultaneous dispatch and issue: both take effect and occupancy_o is unchanged.
- Reset asserted mid-operation discards all entries immediately; there is no drain.
- Tag 0 never wakes anything, even when its channel valid bit is set.

## Test plan
- Reset then a single dispatch with all sources valid (vals 0xA, 0xB, 0xC, dest 3): issue_valid_o=1 the next cycle with those values; occupancy 1→0 after the handshake.
- Dispatch with src0 tag 5 pending, then bcast ch2 tag5=0xD0 in cycle C: issue_valid_o=1 in cycle C with src0=0xD0.
- Same cycle, ch0 and ch1 both broadcast tag 7 (0x11, 0x22) to a pending source: the captured value is 0x11. ch0 valid with tag 0: no wakeup.
- Fill all 4 entries with ready instructions (dest 1..4) while issue_ready_i=0: disp_ready_o=0 and a fifth dispatch is ignored. Then hold issue_ready_i=1: issues come out in order 1, 2, 3, 4.
- Dispatch B ready while older A waits on tag 9: B issues first. After tag 9 is broadcast, A issues.
- With 3 busy entries, assert flush_i together with disp_valid_i: occupancy_o=0 next cycle and the dispatched instruction never issues. Also, drop reset_ni mid-stream: outputs go to their reset values without waiting for a clock.
